gray_ptr_ctrl: RTL and testbench
================================

// Module: gray_ptr_ctrl
// PURPOSE
//  Per-domain pointer controller for the asynchronous FIFO, one instance per clock domain.
//  SIDE=0 is the write side and SIDE=1 is the read side.
//  Keeps an (ADDR_W+1)-bit binary/Gray pointer and synchronises the remote Gray pointer.
//  Produces the RAM address, full/empty, almost-full/almost-empty and a fill level.
//  Generalises the fixed 4-bit dual Gray counter: all outputs are registered, with a
//  built-in synchroniser and flag logic.
// PARAMETERS
//  ADDR_W       4  address width; DEPTH = 2**ADDR_W; legal range >= 2
//  SIDE         0  0 = write (flag = full), 1 = read (flag = empty)
//  SYNC_STAGES  2  flops in the remote-pointer synchroniser; legal range >= 2
//  ALMOST_TH    2  almost threshold in entries; legal range 1..DEPTH-1
// PORTS
//  clk          in   1         domain clock
//  reset_n      in   1         asynchronous active-low reset
//  inc          in   1         push (SIDE=0) or pop (SIDE=1) request
//  remote_gray  in   ADDR_W+1  Gray pointer from the other domain, unsynchronised
//  accept       out  1         inc & ~flag (combinational); pointer advances this edge
//  bin_addr     out  ADDR_W    RAM address = bin_ptr[ADDR_W-1:0] (registered)
//  gray_ptr     out  ADDR_W+1  registered Gray pointer, sent to the remote domain
//  flag         out  1         full (SIDE=0) or empty (SIDE=1), registered
//  almost_flag  out  1         almost-full or almost-empty, registered
//  level        out  ADDR_W+1  entries in the FIFO as seen from this domain, registered
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): bin_ptr=0, gray_ptr=0, all sync flops=0, level=0.
//    SIDE=0: flag=0, almost_flag=0.  SIDE=1: flag=1, almost_flag=1.
//  - Pointer advance:
//    - bin_nxt = bin_ptr + accept, modulo 2**(ADDR_W+1); gray_nxt = bin_nxt ^ (bin_nxt>>1).
//    - gray_ptr is loaded from gray_nxt, never decoded from bin_ptr, so it is glitch-free for CDC.
//  - Wrap: after DEPTH accepts the MSB toggles and bin_addr returns to 0; after 2*DEPTH accepts
//    bin_ptr returns to 0. Only one gray_ptr bit changes per accept.
//  - inc while flag=1: accept=0 and the pointer holds. This is not an error; no overflow/underflow occurs.
//  - Synchroniser: rsync = remote_gray after SYNC_STAGES clk edges.
//    rbin = Gray-to-binary(rsync), computed XOR-prefix from the MSB down.
//  - Full (SIDE=0): flag <= (gray_nxt == {~rsync[A:A-1], rsync[A-2:0]}), where A = ADDR_W.
//  - Empty (SIDE=1): flag <= (gray_nxt == rsync).
//  - Level:
//    - SIDE=0: level <= bin_nxt - rbin.  SIDE=1: level <= rbin - bin_nxt.
//    - Mod 2**(A+1); the result is always in 0..DEPTH.
//  - Almost flags:
//    - SIDE=0: almost_flag <= (level_nxt >= DEPTH-ALMOST_TH).
//    - SIDE=1: almost_flag <= (level_nxt <= ALMOST_TH).
//  - Latency:
//    - A local accept updates flag, level and almost_flag on the same edge that updates the pointer,
//      so a write of the last free slot shows full on the next cycle.
//    - A remote pointer change reaches flag and level SYNC_STAGES+1 edges later.
//      Flags are pessimistic: they assert immediately and deassert late. Never optimistic.
//  - Simultaneous local accept and remote change: both use bin_nxt and the current rsync.
//    The remote change is picked up later with no lost update.
//  - flag, almost_flag and level all depend on rsync through the level/compare logic, so
//    they are mutually consistent at every edge. With SIDE=0, flag=1 implies level=DEPTH.
// TESTING
//  1. Reset, SIDE=0/1, ADDR_W=4 -> all pointers 0; write side full=0, afull=0, level=0;
//     read side empty=1, aempty=1.
//  2. Write side, remote_gray held 0, inc=1 for 20 cycles -> accept for 16 cycles;
//     full=1 after the 16th accept; level=16; gray_ptr=5'b11000; afull=1 from level 14.
//  3. Read side, remote_gray steps to gray(5) -> empty=0 and level=5, both 3 edges later (SYNC_STAGES=2).
//     Then 5 pops -> empty=1 on the edge of the 5th pop.
//  4. Wrap: 40 accepts with the remote tracking -> bin_addr wraps 15->0, MSB toggles at 16 and 32;
//     a checker confirms gray_ptr Hamming distance <= 1 per edge.
//  5. inc=1 with full=1 (or empty=1) -> accept=0; pointer, level and flags unchanged.
//  6. Assert reset_n mid-burst off a clock edge -> outputs take reset values immediately;
//     normal operation resumes after release.

Source files
------------

// File: rtl/gray_ptr_ctrl.sv
// ============================================================================
// Module : gray_ptr_ctrl
// Brief  : Per-domain async-FIFO pointer controller (binary/Gray pointer,
//          remote-pointer synchroniser, full/empty, almost flags, fill level).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_ptr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SIDE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_TH   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic [ADDR_W:0]   remote_gray,
  output logic              accept,
  output logic [ADDR_W-1:0] bin_addr,
  output logic [ADDR_W:0]   gray_ptr,
  output logic              flag,
  output logic              almost_flag,
  output logic [ADDR_W:0]   level
);

  localparam int              C_PW        = ADDR_W + 1;
  localparam logic [ADDR_W:0] C_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic            C_FLAG_RST  = (SIDE != 0);

  logic [ADDR_W:0] r_bin_ptr;
  logic [ADDR_W:0] r_gray_ptr;
  logic            r_flag;
  logic            r_almost;
  logic [ADDR_W:0] r_level;
  logic [ADDR_W:0] r_sync [SYNC_STAGES];

  logic [ADDR_W:0] w_bin_nxt;
  logic [ADDR_W:0] w_gray_nxt;
  logic [ADDR_W:0] w_rsync;
  logic [ADDR_W:0] w_rbin;
  logic [ADDR_W:0] w_level_nxt;
  logic            w_flag_nxt;
  logic            w_almost_nxt;
  logic            w_accept;

  // Flag is registered, so a blocked request never moves the pointer.
  assign w_accept   = inc & ~r_flag;
  assign w_bin_nxt  = r_bin_ptr + {{ADDR_W{1'b0}}, w_accept};
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  assign w_rsync    = r_sync[SYNC_STAGES-1];

  // Gray-to-binary: each bit is the XOR of all Gray bits from the MSB down.
  genvar gi;
  generate
    for (gi = 0; gi < C_PW; gi++) begin : g_g2b
      assign w_rbin[gi] = ^w_rsync[ADDR_W:gi];
    end
  endgenerate

  generate
    if (SIDE == 0) begin : g_write
      localparam logic [ADDR_W:0] C_AFULL_TH = C_DEPTH - C_PW'(ALMOST_TH);
      assign w_level_nxt  = w_bin_nxt - w_rbin;
      assign w_flag_nxt   = (w_gray_nxt ==
                             {~w_rsync[ADDR_W:ADDR_W-1], w_rsync[ADDR_W-2:0]});
      assign w_almost_nxt = (w_level_nxt >= C_AFULL_TH);
    end else begin : g_read
      localparam logic [ADDR_W:0] C_AEMPTY_TH = C_PW'(ALMOST_TH);
      assign w_level_nxt  = w_rbin - w_bin_nxt;
      assign w_flag_nxt   = (w_gray_nxt == w_rsync);
      assign w_almost_nxt = (w_level_nxt <= C_AEMPTY_TH);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Gray register is loaded from gray_nxt, never decoded, so it stays glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin_ptr  <= '0;
      r_gray_ptr <= '0;
      r_flag     <= C_FLAG_RST;
      r_almost   <= C_FLAG_RST;
      r_level    <= '0;
    end else begin
      r_bin_ptr  <= w_bin_nxt;
      r_gray_ptr <= w_gray_nxt;
      r_flag     <= w_flag_nxt;
      r_almost   <= w_almost_nxt;
      r_level    <= w_level_nxt;
    end
  end

  assign accept      = w_accept;
  assign bin_addr    = r_bin_ptr[ADDR_W-1:0];
  assign gray_ptr    = r_gray_ptr;
  assign flag        = r_flag;
  assign almost_flag = r_almost;
  assign level       = r_level;

endmodule

`default_nettype wire

// File: tb/tb_gray_ptr_ctrl.sv
// ============================================================================
// Module : tb_gray_ptr_ctrl
// Brief  : Write-side and read-side gray_ptr_ctrl against a count-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gray_ptr_ctrl;

  localparam int AW = 4;
  localparam int D  = 16;
  localparam int TH = 2;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          inc_w, inc_r;
  logic [AW:0]   rem_w, rem_r;
  logic          acc_w, acc_r;
  logic [AW-1:0] addr_w, addr_r;
  logic [AW:0]   gray_w, gray_r;
  logic          flag_w, flag_r;
  logic          alm_w, alm_r;
  logic [AW:0]   lvl_w, lvl_r;

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.ADDR_W(AW), .SIDE(0), .SYNC_STAGES(SS), .ALMOST_TH(TH)) u_wr (
    .clk(clk), .reset_n(reset_n), .inc(inc_w), .remote_gray(rem_w),
    .accept(acc_w), .bin_addr(addr_w), .gray_ptr(gray_w), .flag(flag_w),
    .almost_flag(alm_w), .level(lvl_w));

  gray_ptr_ctrl #(.ADDR_W(AW), .SIDE(1), .SYNC_STAGES(SS), .ALMOST_TH(TH)) u_rd (
    .clk(clk), .reset_n(reset_n), .inc(inc_r), .remote_gray(rem_r),
    .accept(acc_r), .bin_addr(addr_r), .gray_ptr(gray_r), .flag(flag_r),
    .almost_flag(alm_r), .level(lvl_r));

  int n_vec = 0;
  int n_err = 0;
  int n_acc_w = 0;

  // Model: plain entry counts; side 0 = writer, side 1 = reader.
  int       lcnt [2];
  int       rcnt [2];
  int       mlvl [2];
  bit       mflag[2];
  bit       malm [2];
  int       hist [2][SS];
  logic [AW:0] prev_gray[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v % (2*D));
    return b ^ (b >> 1);
  endfunction

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      lcnt[s] = 0; rcnt[s] = 0; mlvl[s] = 0; prev_gray[s] = '0;
      for (int k = 0; k < SS; k++) hist[s][k] = 0;
    end
    mflag[0] = 1'b0; malm[0] = 1'b0;
    mflag[1] = 1'b1; malm[1] = 1'b1;
  endtask

  task automatic model_edge(input int s, input bit acc, input int rnow);
    int seen;
    seen = hist[s][0];
    for (int k = 0; k < SS-1; k++) hist[s][k] = hist[s][k+1];
    hist[s][SS-1] = rnow;
    lcnt[s] = lcnt[s] + (acc ? 1 : 0);
    if (s == 0) begin
      mlvl[0]  = lcnt[0] - seen;
      mflag[0] = (mlvl[0] == D);
      malm[0]  = (mlvl[0] >= D - TH);
    end else begin
      mlvl[1]  = seen - lcnt[1];
      mflag[1] = (mlvl[1] == 0);
      malm[1]  = (mlvl[1] <= TH);
    end
  endtask

  task automatic check_outputs();
    check_eq("w_flag",  32'(flag_w), 32'(mflag[0]));
    check_eq("w_alm",   32'(alm_w),  32'(malm[0]));
    check_eq("w_level", 32'(lvl_w),  32'(mlvl[0]));
    check_eq("w_addr",  32'(addr_w), 32'(lcnt[0] % D));
    check_eq("w_gray",  32'(gray_w), 32'(to_gray(lcnt[0])));
    check_eq("w_gray_step", 32'($countones(gray_w ^ prev_gray[0]) <= 1), 32'd1);
    check_eq("r_flag",  32'(flag_r), 32'(mflag[1]));
    check_eq("r_alm",   32'(alm_r),  32'(malm[1]));
    check_eq("r_level", 32'(lvl_r),  32'(mlvl[1]));
    check_eq("r_addr",  32'(addr_r), 32'(lcnt[1] % D));
    check_eq("r_gray",  32'(gray_r), 32'(to_gray(lcnt[1])));
    check_eq("r_gray_step", 32'($countones(gray_r ^ prev_gray[1]) <= 1), 32'd1);
    prev_gray[0] = gray_w;
    prev_gray[1] = gray_r;
  endtask

  // Starts just after a falling edge; ends after the next falling-edge check.
  task automatic cycle(input bit iw, input bit ir, input bit step_rw, input bit step_rr);
    bit aw, ar;
    if (step_rw && rcnt[0] < lcnt[0]) rcnt[0]++;
    if (step_rr && rcnt[1] - lcnt[1] < D) rcnt[1]++;
    inc_w = iw; inc_r = ir;
    rem_w = to_gray(rcnt[0]);
    rem_r = to_gray(rcnt[1]);
    #1;
    aw = iw && !mflag[0];
    ar = ir && !mflag[1];
    check_eq("w_accept", 32'(acc_w), 32'(aw));
    check_eq("r_accept", 32'(acc_r), 32'(ar));
    if (acc_w) n_acc_w++;
    @(posedge clk);
    model_edge(0, aw, rcnt[0]);
    model_edge(1, ar, rcnt[1]);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic random_block(input int n);
    int pw, pr, prw, prr;
    pw  = $urandom_range(95, 5);
    pr  = $urandom_range(95, 5);
    prw = $urandom_range(95, 5);
    prr = $urandom_range(95, 5);
    for (int c = 0; c < n; c++) begin
      cycle($urandom_range(99) < pw, $urandom_range(99) < pr,
            $urandom_range(99) < prw, $urandom_range(99) < prr);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    inc_w = 1'b0; inc_r = 1'b0; rem_w = '0; rem_r = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // Fill the writer with the reader stalled.
    n_acc_w = 0;
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t2_accepts", 32'(n_acc_w), 32'd16);
    check_eq("t2_gray",    32'(gray_w),  32'b11000);
    check_eq("t2_level",   32'(lvl_w),   32'd16);
    check_eq("t2_full",    32'(flag_w),  32'd1);

    // Remote write pointer jumps to 5: visible on the third edge.
    rcnt[1] = 5;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_still_empty", 32'(flag_r), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_not_empty", 32'(flag_r), 32'd0);
    check_eq("t3_level",     32'(lvl_r),  32'd5);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t3_empty_again", 32'(flag_r), 32'd1);

    // Streaming with the remote tracking, through several wraps.
    repeat (90) cycle(1'b1, 1'b1, 1'b1, 1'b1);

    for (int b = 0; b < 12; b++) random_block(200);

    // Asynchronous reset between clock edges, mid-burst.
    repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    reset_model();
    inc_w = 1'b0; inc_r = 1'b0; rem_w = '0; rem_r = '0;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    check_outputs();

    for (int b = 0; b < 3; b++) random_block(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
